// File: rtl/alu_output_stage_if.sv
// Bundle between the ALU output stage and its environment: the ALU result handshake and the four response ports.
// When ALU_OUT_PARITY_EN is defined, the bundle also carries the out_par signal.
interface alu_output_stage_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [0:63] alu_result;
    logic [0:3]  alu_cmd;
    logic [0:1]  alu_tag;
    logic [1:4]  port_hold;
    logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
    logic [0:31] out_data1, out_data2, out_data3, out_data4;
`ifdef ALU_OUT_PARITY_EN
    logic [1:4]  out_par;

    modport master (
        output alu_valid, alu_result, alu_cmd, alu_tag, port_hold,
        input  alu_ready, out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4, out_par
    );
    modport slave (
        input  alu_valid, alu_result, alu_cmd, alu_tag, port_hold,
        output alu_ready, out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4, out_par
    );
`else
    modport master (
        output alu_valid, alu_result, alu_cmd, alu_tag, port_hold,
        input  alu_ready, out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4
    );
    modport slave (
        input  alu_valid, alu_result, alu_cmd, alu_tag, port_hold,
        output alu_ready, out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4
    );
`endif
endinterface

// File: rtl/alu_output_stage.sv
// ALU return-path stage: this block classifies 64-bit results, queues them, and sends each one as a 32-bit one-cycle response on its port.
// Defining ALU_OUT_PARITY_EN adds registered odd parity on out_par.
module alu_output_stage #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic              c_clk,
    input logic              reset_n,
    alu_output_stage_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [1:0]  tag;
    } entry_t;

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic [1:0]       resp_q [4];
    logic [1:0]       resp_d [4];
    logic [31:0]      data_q [4];
    logic [31:0]      data_d [4];
`ifdef ALU_OUT_PARITY_EN
    logic [3:0]       par_q, par_d;
`endif

    entry_t     push_entry, head;
    logic       push, pop;
    logic [0:3] hold_by_tag;

    // Tag 0..3 addresses port_hold[1..4]; the slice copy lines the two up.
    assign hold_by_tag = bus.port_hold;
    assign head        = mem_q[rd_ptr_q];
    assign push        = bus.alu_valid && ready_q;
    assign pop         = (count_q != '0) && !hold_by_tag[head.tag];

    always_comb begin
        push_entry.data = bus.alu_result[32:63];
        push_entry.tag  = bus.alu_tag;
        push_entry.err  = 1'b1;
        case (bus.alu_cmd)
            4'd1, 4'd2: push_entry.err = |bus.alu_result[0:31];
            4'd5, 4'd6: push_entry.err = 1'b0;
            default:    push_entry.err = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        ready_d = count_d < DEPTH_C;
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            resp_d[i] = '0;
            data_d[i] = '0;
            if (pop && head.tag == 2'(i)) begin
                resp_d[i] = head.err ? 2'b10 : 2'b01;
                data_d[i] = head.data;
            end
        end
`ifdef ALU_OUT_PARITY_EN
        for (int unsigned i = 0; i < 4; i++) par_d[i] = ~^data_d[i];
`endif
    end

    always_ff @(posedge c_clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                resp_q[i] <= '0;
                data_q[i] <= '0;
            end
`ifdef ALU_OUT_PARITY_EN
            par_q <= '1;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            for (int unsigned i = 0; i < 4; i++) begin
                resp_q[i] <= resp_d[i];
                data_q[i] <= data_d[i];
            end
`ifdef ALU_OUT_PARITY_EN
            par_q <= par_d;
`endif
        end
    end

    assign bus.alu_ready = ready_q;
    assign bus.out_resp1 = resp_q[0];
    assign bus.out_resp2 = resp_q[1];
    assign bus.out_resp3 = resp_q[2];
    assign bus.out_resp4 = resp_q[3];
    assign bus.out_data1 = data_q[0];
    assign bus.out_data2 = data_q[1];
    assign bus.out_data3 = data_q[2];
    assign bus.out_data4 = data_q[3];
`ifdef ALU_OUT_PARITY_EN
    assign bus.out_par = {par_q[0], par_q[1], par_q[2], par_q[3]};
`endif
endmodule

// File: tb/tb_alu_output_stage.sv
// Directed self-checking bench for alu_output_stage; with ALU_OUT_PARITY_EN defined it also checks out_par.
module tb_alu_output_stage;
    logic c_clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_output_stage_if bus ();

    alu_output_stage #(.FIFO_DEPTH(4)) dut (
        .c_clk   (c_clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 c_clk = ~c_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] resp_of(input int p);
        case (p)
            1:       return bus.out_resp1;
            2:       return bus.out_resp2;
            3:       return bus.out_resp3;
            default: return bus.out_resp4;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input int p);
        case (p)
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            3:       return bus.out_data3;
            default: return bus.out_data4;
        endcase
    endfunction

    // port 0 means no response expected anywhere; data is not checked on error responses
    task automatic check_ports(input string tag, input int port, input logic [1:0] resp, input logic [31:0] data);
        for (int p = 1; p <= 4; p++) begin
            if (p == port) begin
                check_eq($sformatf("%s_resp%0d", tag, p), 64'(resp_of(p)), 64'(resp));
                if (resp != 2'b10)
                    check_eq($sformatf("%s_data%0d", tag, p), 64'(data_of(p)), 64'(data));
            end else begin
                check_eq($sformatf("%s_resp%0d", tag, p), 64'(resp_of(p)), 64'd0);
                check_eq($sformatf("%s_data%0d", tag, p), 64'(data_of(p)), 64'd0);
            end
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic push(input logic [63:0] r, input logic [3:0] c, input logic [1:0] t);
        bus.alu_valid  = 1'b1;
        bus.alu_result = r;
        bus.alu_cmd    = c;
        bus.alu_tag    = t;
        step();
        bus.alu_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alu_valid  = 1'b0;
        bus.alu_result = '0;
        bus.alu_cmd    = '0;
        bus.alu_tag    = '0;
        bus.port_hold  = '0;

        #2;
        check_eq("rst_ready", 64'(bus.alu_ready), 64'd0);
        check_ports("rst", 0, 2'b00, 32'h0);
`ifdef ALU_OUT_PARITY_EN
        check_eq("rst_par", 64'(bus.out_par), 64'hF);
`endif
        @(posedge c_clk);
        #3 reset_n = 1'b1;
        step();
        check_eq("ready_after_rst", 64'(bus.alu_ready), 64'd1);

        // Add without carry: one cycle of latency, then one cycle of response
        push(64'h0000_0000_0000_0005, 4'd1, 2'd2);
        check_ports("add_lat", 0, 2'b00, 32'h0);
        step();
        check_ports("add_ok", 3, 2'b01, 32'h0000_0005);
        step();
        check_ports("add_gone", 0, 2'b00, 32'h0);

        // Carry on add, borrow on sub, shift discarding upper bits
        push(64'h0000_0001_0000_0000, 4'd1, 2'd0);
        push(64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 2'd0);
        check_ports("add_ovf", 1, 2'b10, 32'h0);
        step();
        check_ports("sub_unf", 1, 2'b10, 32'h0);
        step();
        check_ports("ovf_gone", 0, 2'b00, 32'h0);
        push(64'h0000_0001_8000_0000, 4'd5, 2'd0);
        step();
        check_ports("shl_ok", 1, 2'b01, 32'h8000_0000);
        push(64'h0000_0000_0000_0003, 4'd2, 2'd1);
        step();
        check_ports("sub_ok", 2, 2'b01, 32'h0000_0003);
        push(64'h0000_0000_0000_0009, 4'd3, 2'd1);
        step();
        check_ports("bad_cmd", 2, 2'b10, 32'h0);

        // Fill the FIFO behind a held port 1
        bus.port_hold = 4'b1000;
        push(64'h11, 4'd1, 2'd0);
        push(64'h22, 4'd1, 2'd0);
        push(64'h33, 4'd1, 2'd0);
        check_eq("ready_at3", 64'(bus.alu_ready), 64'd1);
        push(64'h44, 4'd1, 2'd0);
        check_eq("ready_full", 64'(bus.alu_ready), 64'd0);
        check_ports("full_held", 0, 2'b00, 32'h0);
        push(64'h55, 4'd1, 2'd0);
        check_eq("ready_still_full", 64'(bus.alu_ready), 64'd0);
        bus.port_hold = 4'b0000;
        step();
        check_ports("drain1", 1, 2'b01, 32'h11);
        check_eq("ready_first_pop", 64'(bus.alu_ready), 64'd1);
        step();
        check_ports("drain2", 1, 2'b01, 32'h22);
        step();
        check_ports("drain3", 1, 2'b01, 32'h33);
        step();
        check_ports("drain4", 1, 2'b01, 32'h44);
        step();
        check_ports("no_fifth", 0, 2'b00, 32'h0);

        // Head-of-line: held port 1 blocks port 4; hold on port 2 is ignored
        bus.port_hold = 4'b1000;
        push(64'hA1, 4'd1, 2'd0);
        push(64'hB4, 4'd1, 2'd3);
        check_ports("hol_blk1", 0, 2'b00, 32'h0);
        step();
        check_ports("hol_blk2", 0, 2'b00, 32'h0);
        bus.port_hold = 4'b0100;
        step();
        check_ports("hol_p1", 1, 2'b01, 32'hA1);
        step();
        check_ports("hol_p4", 4, 2'b01, 32'hB4);
        bus.port_hold = 4'b0000;
        step();
        check_ports("hol_done", 0, 2'b00, 32'h0);

        push(64'h0000_0000_0000_0001, 4'd1, 2'd0);
        step();
        check_ports("par_data", 1, 2'b01, 32'h1);
`ifdef ALU_OUT_PARITY_EN
        check_eq("par_one", 64'(bus.out_par), 64'h7);
`endif

        // Reset while three entries are queued and one response is in flight
        bus.port_hold = 4'b1000;
        push(64'h61, 4'd1, 2'd0);
        push(64'h62, 4'd1, 2'd0);
        push(64'h63, 4'd1, 2'd0);
        bus.port_hold = 4'b0000;
        step();
        check_ports("pre_rst", 1, 2'b01, 32'h61);
        #2 reset_n = 1'b0;
        #1;
        check_ports("mid_rst", 0, 2'b00, 32'h0);
        check_eq("mid_rst_ready", 64'(bus.alu_ready), 64'd0);
`ifdef ALU_OUT_PARITY_EN
        check_eq("mid_rst_par", 64'(bus.out_par), 64'hF);
`endif
        #1 reset_n = 1'b1;
        step();
        check_eq("post_rst_ready", 64'(bus.alu_ready), 64'd1);
        check_ports("post_rst1", 0, 2'b00, 32'h0);
        step();
        check_ports("post_rst2", 0, 2'b00, 32'h0);
        step();
        check_ports("post_rst3", 0, 2'b00, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_output_stage.md
# alu_output_stage

Return-path stage of the multiport ALU, the counterpart to the input stage that zero-extends 32-bit port operands onto the 64-bit ALU datapath. It accepts 64-bit ALU results tagged with the requesting port and command, and classifies each result as success or overflow/underflow/invalid. Results are queued in a small FIFO, narrowed back to 32 bits and delivered as a one-cycle response on the requesting port. Per-port hold inputs apply backpressure.

## Interface
- FIFO_DEPTH, 4, result queue entries; power of two, 2..16
- c_clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- alu_valid  input  1  result present on alu_* this cycle
- alu_ready  output  1  stage can accept a result; registered
- alu_result  input  [0:63]  ALU result, bit 0 = MSB
- alu_cmd  input  [0:3]  command that produced the result
- alu_tag  input  [0:1]  requesting port: 0..3 = port 1..4
- port_hold  input  [1:4]  port N cannot take a response this cycle
- out_resp1..out_resp4  output  [0:1] each  00 none, 01 success, 10 error, 11 unused
- out_data1..out_data4  output  [0:31] each  response data
- out_par  output  [1:4]  odd parity of out_dataN; only with ALU_OUT_PARITY_EN

## Operation
- Push: at a rising edge with alu_valid=1 and alu_ready=1, write {class, alu_result[32:63], alu_tag} to the FIFO tail. When alu_ready=0, alu_valid is ignored and the ALU holds its result.
- Classification happens at push:
  - cmd 1 (add): error if alu_result[0:31] != 0 (carry out), else success.
  - cmd 2 (sub): error if alu_result[0:31] != 0 (borrow, so upper bits are all ones), else success.
  - cmd 5, 6 (shift left/right): always success. Upper bits are discarded.
  - Any other cmd: error.
  - Data is alu_result[32:63] in every case. On error the data is still sent, and the bench must not check it.
- Pop: at a rising edge where the FIFO is non-empty and port_hold of the head's port is 0, remove the head.
  - The tagged port's out_resp and out_data registers load the class and data.
  - All other ports load 00 and zero.
- No pop at an edge: all out_resp and out_data load 0. Each response therefore lasts exactly one cycle.
- Head-of-line blocking: a held head entry stalls every queued entry, including entries for other ports. Order is strictly FIFO.
- Push and pop may occur at the same edge. Count is unchanged and pointers advance modulo FIFO_DEPTH.

## Timing
- Reset values (reset_n low, asynchronous): FIFO pointers 0, count 0, alu_ready 0, all out_resp 00, all out_data 0, out_par 1.
- alu_ready is 1 from the first rising edge after reset_n deasserts.
- alu_ready is registered as next_count < FIFO_DEPTH.
  - With count = FIFO_DEPTH-1, an edge with a push and no pop drives ready to 0.
  - Ready returns to 1 at the edge of the first pop.
  - When full, no push is accepted even if a pop happens at the same edge.
- Latency with an empty FIFO and no hold: accepted at edge k, response visible for the cycle after edge k+1. That is one cycle of latency and one cycle of response.
- Throughput: one response per cycle when not held.
- Reset mid-operation: queued entries are discarded and no response is emitted for them. An in-flight response is cleared immediately.
- port_hold is sampled only for the head entry's port. Hold on other ports has no effect.

## Configuration
- ALU_OUT_PARITY_EN defined:
  - out_par[1:4] is present.
  - out_par[N] is registered with out_dataN and equals ~^out_dataN (odd parity).
  - Reset value is 1.
- Not defined: the out_par port does not exist. Logic and timing are otherwise identical.

## Test plan
- Add, no overflow: push result 0x0000_0000_0000_0005, cmd 1, tag 2, holds 0. out_resp3=01 and out_data3=0x0000_0005 for exactly one cycle, starting one edge after the accept. Other ports read 00 and 0.
- Overflow/underflow: push add with result 0x0000_0001_0000_0000, then sub with 0xFFFF_FFFF_FFFF_FFFF, both tag 0. out_resp1 shows 10, then 10 on consecutive cycles. Cmd 5 with 0x0000_0001_8000_0000 gives 01 and data 0x8000_0000.
- Invalid cmd: cmd 3 with tag 1 gives out_resp2=10.
- Full/backpressure: port_hold=1 for port 1, push 4 tag-0 results then a 5th.
  - alu_ready drops after the 4th push and the 5th is not accepted.
  - Release the hold: 4 responses come out on back-to-back cycles in push order, and alu_ready rises at the first pop edge.
- Head-of-line: head tag 0 held, next entry tag 3. Port 4 gets nothing until port 1's hold drops. Then port 1 responds, and port 4 responds the following cycle.
- Reset mid-queue: with 3 entries queued, pulse reset_n low between edges. Outputs clear immediately, no further responses appear, and alu_ready is 0 during reset and 1 after the first edge. With ALU_OUT_PARITY_EN, data 0x0000_0001 gives out_par=0.
